operand_loader: RTL and testbench

Operand entry sequencer for the 4-bit ALU board design. Sits directly upstream of the X/Y operand registers. It turns the raw, bouncing, active-low load pushbutton into clean single-cycle load strobes, and steps automatically X → Y → ready, so only one button is needed to enter both operands. It also presents the captured switch value and a status for the LEDs.

---
 rtl/alu_pkg.sv | 12 +
 rtl/key_debouncer.sv | 65 ++++++
 rtl/operand_loader.sv | 90 +++++++++
 tb/tb_operand_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU board: operand loader state encoding.
package alu_pkg;

  localparam int LOADER_STATE_W = 2;

  typedef enum logic [LOADER_STATE_W-1:0] {
    WAIT_X = 2'd0,
    WAIT_Y = 2'd1,
    READY  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Load key conditioning: 2-flop synchronizer, debounce window, one-cycle press pulse.
// The debounce counter exists only when OPERAND_LOADER_DEBOUNCE_EN is defined.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press_pulse
);

  logic sync1;
  logic sync2;
  logic key_level;
  logic key_level_d;

  // NOTE: flops reset to the idle (released) level so reset release never looks like a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The level flips only after the new value has been seen for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_level <= 1'b1;
      cnt       <= '0;
    end else if (sync2 == key_level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      key_level <= sync2;
      cnt       <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = (DEBOUNCE_CYCLES >= 1);
  assign key_level = sync2;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_level_d <= 1'b1;
    end else begin
      key_level_d <= key_level;
    end
  end

  // High for exactly the one cycle after the debounced level falls; release gives nothing.
  assign press_pulse = key_level_d & ~key_level;

endmodule

// File: rtl/operand_loader.sv
// Operand entry sequencer: one debounced key steps X -> Y -> ready, strobing the operand registers.
module operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      key_n,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      load_x,
  output logic                      load_y,
  output logic                      operands_valid,
  output logic [LOADER_STATE_W-1:0] state
);

  loader_state_t state_q;
  loader_state_t state_d;
  logic          press;
  logic          load_x_d;
  logic          load_y_d;
  logic          valid_d;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .press_pulse(press)
  );

  // Strobes, status and the captured value all move on the same edge as the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= WAIT_X;
      load_x         <= 1'b0;
      load_y         <= 1'b0;
      operands_valid <= 1'b0;
      data_out       <= '0;
    end else begin
      state_q        <= state_d;
      load_x         <= load_x_d;
      load_y         <= load_y_d;
      operands_valid <= valid_d;
      if (load_x_d || load_y_d) begin
        data_out <= data_in;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_X:  if (press) state_d = WAIT_Y;
      WAIT_Y:  if (press) state_d = READY;
      READY:   if (press) state_d = WAIT_Y;
      default: state_d = WAIT_X;
    endcase
  end

  always_comb begin
    load_x_d = 1'b0;
    load_y_d = 1'b0;
    valid_d  = operands_valid;
    if (press) begin
      case (state_q)
        WAIT_X: begin
          load_x_d = 1'b1;
          valid_d  = 1'b0;
        end
        WAIT_Y: begin
          load_y_d = 1'b1;
          valid_d  = 1'b1;
        end
        READY: begin
          load_x_d = 1'b1;
          valid_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader; D follows OPERAND_LOADER_DEBOUNCE_EN (4 when defined, else 0).
module tb_operand_loader;

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int D = 4;
`else
  localparam int D = 0;
`endif

  logic       clock;
  logic       reset;
  logic       key_n;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       load_x;
  logic       load_y;
  logic       operands_valid;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int nx = 0;
  int ny = 0;
  int overlap = 0;

  operand_loader #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .key_n         (key_n),
    .data_in       (data_in),
    .data_out      (data_out),
    .load_x        (load_x),
    .load_y        (load_y),
    .operands_valid(operands_valid),
    .state         (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe tally, sampled mid-cycle.
  always @(negedge clock) begin
    if (load_x) nx++;
    if (load_y) ny++;
    if (load_x && load_y) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press_check(input string tag, input logic [3:0] d, input logic exp_x,
                             input logic exp_y, input logic [1:0] exp_state, input logic exp_valid);
    data_in = d;
    key_n   = 1'b0;
    repeat (D + 2) tick();
    check({tag, "_early"}, {30'd0, load_x, load_y}, 32'd0);
    tick();
    check({tag, "_strobe"}, {30'd0, load_x, load_y}, {30'd0, exp_x, exp_y});
    check({tag, "_data"}, {28'd0, data_out}, {28'd0, d});
    check({tag, "_state"}, {30'd0, state}, {30'd0, exp_state});
    check({tag, "_valid"}, {31'd0, operands_valid}, {31'd0, exp_valid});
    tick();
    check({tag, "_after"}, {30'd0, load_x, load_y}, 32'd0);
    repeat (16) tick();
    key_n = 1'b1;
    repeat (D + 6) tick();
  endtask

  initial begin
    int x0;
    int y0;
    reset   = 1'b0;
    key_n   = 1'b1;
    data_in = 4'h0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (50) tick();
    check("idle_data", {28'd0, data_out}, 32'd0);
    check("idle_strobes", {30'd0, load_x, load_y}, 32'd0);
    check("idle_valid", {31'd0, operands_valid}, 32'd0);
    check("idle_state", {30'd0, state}, 32'd0);

    press_check("press1", 4'hA, 1'b1, 1'b0, 2'd1, 1'b0);
    press_check("press2", 4'h3, 1'b0, 1'b1, 2'd2, 1'b1);
    press_check("press3", 4'h5, 1'b1, 1'b0, 2'd1, 1'b0);

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    // Bounce with 2-cycle period never stays low long enough to be accepted.
    x0 = nx;
    y0 = ny;
    data_in = 4'h9;
    for (int i = 0; i < 15; i++) begin
      key_n = 1'b0;
      tick();
      key_n = 1'b1;
      tick();
    end
    repeat (20) tick();
    check("bounce_x", nx, x0);
    check("bounce_y", ny, y0);
    check("bounce_state", {30'd0, state}, 32'd1);
    check("bounce_data", {28'd0, data_out}, 32'h5);
`endif

    // Reset mid-press, key still held on release: fresh press from WAIT_X.
    x0      = nx;
    data_in = 4'h7;
    key_n   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_valid", {31'd0, operands_valid}, 32'd0);
    check("rst_data", {28'd0, data_out}, 32'd0);
    repeat (5) tick();
    check("rst_no_strobe", nx, x0);
    reset = 1'b1;
    repeat (D + 2) tick();
    check("rst_early", {30'd0, load_x, load_y}, 32'd0);
    tick();
    check("rst_load_x", {31'd0, load_x}, 32'd1);
    check("rst_state1", {30'd0, state}, 32'd1);
    check("rst_data1", {28'd0, data_out}, 32'h7);
    tick();
    key_n = 1'b1;
    repeat (D + 6) tick();
    check("rst_one_x", nx, x0 + 1);

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    // Low for D-1 cycles is rejected, exactly D cycles is accepted.
    x0 = nx;
    y0 = ny;
    key_n = 1'b0;
    repeat (D - 1) tick();
    key_n = 1'b1;
    repeat (D + 6) tick();
    check("short_x", nx, x0);
    check("short_y", ny, y0);
    data_in = 4'hC;
    key_n   = 1'b0;
    repeat (D) tick();
    key_n = 1'b1;
    repeat (2) tick();
    check("edge_early", {30'd0, load_x, load_y}, 32'd0);
    tick();
    check("edge_load_y", {31'd0, load_y}, 32'd1);
    check("edge_state", {30'd0, state}, 32'd2);
    check("edge_valid", {31'd0, operands_valid}, 32'd1);
    check("edge_data", {28'd0, data_out}, 32'hC);
    repeat (D + 6) tick();
    check("total_x", nx, 3);
    check("total_y", ny, 2);
`else
    // Single-cycle low pulse is a press without debouncing.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    data_in = 4'h6;
    key_n   = 1'b0;
    tick();
    key_n = 1'b1;
    tick();
    check("pulse_early", {30'd0, load_x, load_y}, 32'd0);
    tick();
    check("pulse_load_x", {31'd0, load_x}, 32'd1);
    check("pulse_data", {28'd0, data_out}, 32'h6);
    tick();
    check("pulse_after", {30'd0, load_x, load_y}, 32'd0);
    repeat (5) tick();
    check("total_x", nx, 4);
    check("total_y", ny, 1);
`endif

    check("no_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
